// File: rtl/arb_pkg.sv
// arb_pkg: shared types and defaults for the IF/MEM memory-port arbiter.
//   arb_state_e : FSM encoding (IDLE / REQ / RESP)
//   arb_owner_e : which requester owns the in-flight transaction
//   mem_cmd_t   : captured request presented to memory
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_cmd_t;

  localparam int STREAK_MAX_DEF = 4;
  localparam int TIMEOUT_DEF    = 64;
  localparam int STREAK_W       = 4;   // STREAK_MAX is limited to 1..15

endpackage

// File: rtl/arb_watchdog.sv
// arb_watchdog: response-phase watchdog.
//   clk, reset : clock, synchronous active-high reset
//   clr        : restart the count (held while not waiting for a response)
//   en         : count this cycle (waiting for a response)
//   expire     : high in the TIMEOUT-th enabled cycle since the last clear
module arb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;

  // Count 0 is the first waiting cycle, so TIMEOUT-1 marks the last one.
  assign expire = en && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || clr)       cnt_q <= '0;
    else if (en && !expire) cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction
// fetch (if_*) and data access (dm_*). One transaction in flight; MEM has
// priority, but after STREAK_MAX consecutive MEM wins while IF waits, IF is
// forced through.
//   if_req/if_addr -> if_gnt, if_rvalid/if_rdata         fetch side
//   dm_req/we/addr/wdata/be -> dm_gnt, dm_rvalid/rdata   data side
//   mem_req/we/addr/wdata/be, mem_ready, mem_rvalid/rdata memory side
//   err : one-cycle pulse when the response watchdog aborts a read
// Optional: define ARB_TIMEOUT_EN to enable the RESP watchdog (TIMEOUT
// cycles); without it err is 0 and RESP waits indefinitely.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int STREAK_MAX = STREAK_MAX_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  input  logic [3:0]  dm_be,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  arb_state_e          state_q, state_d;
  arb_owner_e          owner_q;
  mem_cmd_t            cmd_q;
  logic [STREAK_W-1:0] streak_q;
  logic                if_rvalid_q, dm_rvalid_q;
  logic [31:0]         if_rdata_q, dm_rdata_q;

  logic if_win;
  logic st_done;    // store accepted by memory
  logic rsp_take;   // read data arrived
  logic rsp_abort;  // watchdog gave up on the read
  logic wd_expire;

  assign if_win = if_req && (!dm_req || (streak_q == STREAK_W'(STREAK_MAX)));

  // Next state and grants
  always_comb begin
    state_d   = state_q;
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    st_done   = 1'b0;
    rsp_take  = 1'b0;
    rsp_abort = 1'b0;
    case (state_q)
      IDLE: begin
        if (!reset) begin
          if_gnt = if_win;
          dm_gnt = dm_req && !if_win;
          if (if_req || dm_req) state_d = REQ;
        end
      end
      REQ: begin
        if (mem_ready) begin
          st_done = cmd_q.we;
          state_d = cmd_q.we ? IDLE : RESP;
        end
      end
      RESP: begin
        rsp_take  = mem_rvalid;
        rsp_abort = !mem_rvalid && wd_expire;
        if (rsp_take || rsp_abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Capture, streak and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q     <= OWN_IF;
      cmd_q       <= '0;
      streak_q    <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;

      if (if_gnt) begin
        owner_q  <= OWN_IF;
        cmd_q    <= '{we: 1'b0, addr: if_addr, wdata: 32'h0, be: 4'hF};
        streak_q <= '0;
      end else if (dm_gnt) begin
        owner_q <= OWN_DM;
        cmd_q   <= '{we: dm_we, addr: dm_addr, wdata: dm_wdata, be: dm_be};
        // Only MEM wins that actually made IF wait count toward the streak.
        if (!if_req)                                 streak_q <= '0;
        else if (streak_q != STREAK_W'(STREAK_MAX)) streak_q <= streak_q + 1'b1;
      end

      if (st_done) begin
        dm_rvalid_q <= 1'b1;
        dm_rdata_q  <= '0;
      end

      if (rsp_take || rsp_abort) begin
        if (owner_q == OWN_IF) begin
          if_rvalid_q <= 1'b1;
          if_rdata_q  <= rsp_take ? mem_rdata : 32'h0;
        end else begin
          dm_rvalid_q <= 1'b1;
          dm_rdata_q  <= rsp_take ? mem_rdata : 32'h0;
        end
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic err_q;

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk    (clk),
    .reset  (reset),
    .clr    (state_q != RESP),
    .en     (state_q == RESP),
    .expire (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= rsp_abort;
  end

  assign err = err_q;
`else
  assign wd_expire = 1'b0;
  assign err       = 1'b0;
`endif

  assign mem_req   = (state_q == REQ);
  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign mem_be    = cmd_q.be;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rvalid = dm_rvalid_q;
  assign dm_rdata  = dm_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-ported memory between the instruction-fetch requester (IF) and the data-access requester (MEM stage) of the pipelined core. It sits between the pipeline's fetch and load/store logic and the memory. It grants one transaction at a time, with MEM priority plus an anti-starvation guard for IF. It sequences each transaction through request/accept/response phases and returns responses to the owner.

## Interface
- STREAK_MAX, 4: max consecutive MEM grants while IF is waiting before IF is forced through (1..15)
- TIMEOUT, 64: watchdog limit in cycles for the response phase (only with ARB_TIMEOUT_EN)
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  32  fetch word address
- if_gnt  out  1  one-cycle pulse: IF request captured
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  32  fetched instruction
- dm_req  in  1  data request; held with fields until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  32  data address
- dm_wdata  in  32  store data, already lane-aligned
- dm_be  in  4  byte enables
- dm_gnt  out  1  one-cycle pulse: MEM request captured
- dm_rvalid  out  1  one-cycle pulse: load data valid, or store completed (dm_rdata = 0)
- dm_rdata  out  32  load word (extension done downstream)
- mem_req  out  1  request to memory, registered
- mem_we, mem_addr, mem_wdata, mem_be  out  1/32/32/4  registered copies of the captured request (mem_we = 0, mem_be = 4'hF for IF)
- mem_ready  in  1  memory accepts the request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data
- err  out  1  one-cycle pulse on watchdog abort (0 when ARB_TIMEOUT_EN is absent)

## Operation
- States: IDLE, REQ (mem_req = 1, waiting for mem_ready), RESP (read accepted, waiting for mem_rvalid). An owner register records IF or MEM.
- **IDLE arbitration** (combinational gnt):
  - Only one requester active: that requester wins.
  - Both active: MEM wins, unless streak == STREAK_MAX, in which case IF wins.
- **Capture:** the winner's fields are registered and the FSM moves to REQ.
- **Streak counter:**
  - Increments on a MEM grant while if_req = 1.
  - Clears on any IF grant, and on a MEM grant while if_req = 0.
  - Saturates at STREAK_MAX.
- **REQ + mem_ready:**
  - Read goes to RESP.
  - Write goes to IDLE and pulses dm_rvalid next cycle.
- **RESP + mem_rvalid:** mem_rdata is registered into the owner's rdata, the owner's rvalid pulses next cycle, and the FSM goes to IDLE.
- mem_rvalid outside RESP is ignored. mem_ready outside REQ is ignored.
- rdata outputs hold their last value between pulses. Non-owner rvalid stays 0.
- Reset (any state): state = IDLE, streak = 0, all outputs and registers = 0. An in-flight transaction is dropped with no rvalid.

## Timing
- Cycle 0: req high in IDLE, gnt pulses, capture at the edge.
- Cycle 1: mem_req high.
- mem_ready sampled in cycle k ≥ 1: mem_req low from k+1.
- Reads: mem_rvalid in cycle m > k gives owner rvalid in m+1. The FSM is IDLE in m+1, so a new gnt is possible in m+1.
- Best-case read: gnt at 0, mem_ready at 1, mem_rvalid at 2, rvalid at 3.
- Stores: mem_ready at k gives dm_rvalid at k+1.
- Throughput: at most one transaction in flight.
- Both requests arrive in the same IDLE cycle: exactly one gnt. The loser keeps req high and wins the next IDLE cycle if still eligible.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A counter runs in RESP, clearing on entry.
  - When it reaches TIMEOUT with no mem_rvalid: the owner's rvalid pulses with rdata = 0, err pulses in the same cycle, and the FSM goes to IDLE.
  - A late mem_rvalid is then ignored.
- ARB_TIMEOUT_EN undefined: no counter, err tied to 0, RESP waits indefinitely.

## Structure
- Shared package arb_pkg: state encoding (IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2), owner encoding (OWN_IF = 1'b0, OWN_DM = 1'b1), default STREAK_MAX and TIMEOUT constants.
- One sub-module, arb_watchdog (counter, clear/enable, expire output), instantiated only under ARB_TIMEOUT_EN.

## Test plan
- **IF-only read:** if_req = 1, if_addr = 0x100; mem_ready at cycle 1, mem_rvalid at cycle 2 with 0x00500093 -> if_gnt at 0, mem_addr = 0x100 with mem_req high in cycle 1 only, if_rvalid = 1 with if_rdata = 0x00500093 at cycle 3.
- **Store:** dm_req, dm_we = 1, dm_addr = 0x2004, dm_wdata = 0xAB, dm_be = 4'b0001; mem_ready delayed to cycle 3 -> mem_req high cycles 1–3 with fields stable, dm_rvalid at 4, if_rvalid stays 0.
- **Simultaneous requests:** if_req and dm_req held continuously, zero-wait memory -> grant order MEM ×4 then IF, repeating; IF is never starved beyond STREAK_MAX.
- **Reset mid-operation:** reset asserted in RESP, then mem_rvalid the following cycle -> all outputs 0 after the edge, no rvalid, state IDLE.
- **Watchdog (ARB_TIMEOUT_EN, TIMEOUT = 8):** MEM load with mem_rvalid never asserted -> dm_rvalid and err pulse together after 8 RESP cycles with dm_rdata = 0; a later mem_rvalid is ignored.
- **Stray memory response:** mem_rvalid pulsed while in IDLE -> no rvalid output and no state change.
